// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS window on the M-stage store bus,
// byte FIFO feeding a start/data/stop serialiser with a registered line output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shift, shift_n;
  logic [AW-1:0] rdptr, wrptr;
  logic [CW-1:0] count, count_n;
  logic          overflow;
  logic [7:0]    mem [FIFO_DEPTH];

  logic full, empty, push_req, push, pop, status_wr, tx_n;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = ^{writedata[31:8], dataadr[1:0]};

  assign sel       = (dataadr[31:3] == BASE_ADDR[31:3]);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_req  = memwrite & sel & ~dataadr[2];
  assign push      = push_req & ~full;
  assign status_wr = memwrite & sel & dataadr[2];

  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[2]       = (state != IDLE);
    status[3]       = overflow;
    status[8 +: CW] = count;
    rdata           = (sel && dataadr[2]) ? status : '0;
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_n  = mem[rdptr];
          bitcnt_n = '0;
          baud_n   = BAUD_RELOAD;
          state_n  = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_n  = BAUD_RELOAD;
          state_n = DATA;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_n   = BAUD_RELOAD;
          shift_n  = {1'b0, shift[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = STOP;
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          // Chain straight into the next START so queued frames leave no idle gap.
          if (!empty) begin
            pop      = 1'b1;
            shift_n  = mem[rdptr];
            bitcnt_n = '0;
            baud_n   = BAUD_RELOAD;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    count_n = count + CW'(push) - CW'(pop);

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud      <= '0;
      bitcnt    <= '0;
      shift     <= '0;
      rdptr     <= '0;
      wrptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bitcnt    <= bitcnt_n;
      shift     <= shift_n;
      count     <= count_n;
      tx        <= tx_n;
      irq_empty <= (count_n == '0) && (state_n == IDLE);
      if (push) wrptr <= wrptr + 1'b1;
      if (pop)  rdptr <= rdptr + 1'b1;
      if (status_wr)
        overflow <= 1'b0;
      else if (push_req && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrptr] <= writedata[7:0];
  end

endmodule
